// File: rtl/hamming_rx_corrector.sv
// -----------------------------------------------------------------------------
// hamming_rx_corrector
//
// Receive side of the Hamming(7,4) link. Codewords come in over a valid/ready
// handshake, the syndrome is computed on entry, single-bit errors are corrected
// (optionally) and the 4-bit payload leaves through a 2-stage pipeline.
// Saturating counters keep track of delivered words and of errored words.
//
// Handshake semantics (both ports): a transfer happens on the rising clock edge
// where valid && ready are both 1. A producer holding valid=1 must keep its
// data stable until the transfer; in_valid may still drop without a transfer.
// in_ready only depends on the output side (out_valid, out_ready), never on
// in_valid.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   rcvd_data   codeword [0]=p1 [1]=p2 [2]=d0 [3]=p4 [4]=d1 [5]=d2 [6]=d3
//   in_valid    rcvd_data is valid
//   in_ready    word is accepted this cycle (pipeline can advance)
//   correct_en  1 = correct single-bit errors, 0 = pass data bits raw
//   dec_data    payload {d3,d2,d1,d0}
//   err_flag    syndrome of this word was nonzero
//   err_pos     1-based codeword bit position in error (0 = none)
//   out_valid   dec_data/err_flag/err_pos are valid
//   out_ready   downstream accepts the output word
//   clr_cnt     synchronous clear of both statistic counters
//   word_cnt    delivered words since reset/clear (saturating)
//   corr_cnt    delivered words with err_flag=1 (saturating)
// -----------------------------------------------------------------------------
module hamming_rx_corrector #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       rcvd_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             correct_en,
  output logic [3:0]       dec_data,
  output logic             err_flag,
  output logic [2:0]       err_pos,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] corr_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Stage 1: captured codeword plus its syndrome
  logic [6:0]       s1_cw_q,   s1_cw_d;
  logic [2:0]       s1_syn_q,  s1_syn_d;
  logic             s1_ce_q,   s1_ce_d;
  logic             s1_v_q,    s1_v_d;
  // Stage 2: registered outputs
  logic [3:0]       out_data_q, out_data_d;
  logic             out_err_q,  out_err_d;
  logic [2:0]       out_pos_q,  out_pos_d;
  logic             out_v_q,    out_v_d;
  // Statistics
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;

  logic             advance;
  logic             out_hs;
  logic [2:0]       syn_in;
  logic [2:0]       flip_idx;
  logic [6:0]       flip_mask;
  logic [6:0]       fixed_cw;

  // The whole pipeline moves as one; a stalled output freezes stage 1 too.
  assign advance  = !out_v_q || out_ready;
  assign in_ready = advance;
  assign out_hs   = out_v_q && out_ready;

  // Syndrome bit k is the parity over all 1-based positions with bit k set.
  always_comb begin
    syn_in    = 3'd0;
    syn_in[0] = rcvd_data[0] ^ rcvd_data[2] ^ rcvd_data[4] ^ rcvd_data[6];
    syn_in[1] = rcvd_data[1] ^ rcvd_data[2] ^ rcvd_data[5] ^ rcvd_data[6];
    syn_in[2] = rcvd_data[3] ^ rcvd_data[4] ^ rcvd_data[5] ^ rcvd_data[6];
  end

  // A nonzero syndrome names the flipped bit directly (1-based position).
  always_comb begin
    flip_idx  = s1_syn_q - 3'd1;
    flip_mask = 7'd0;
    if ((s1_syn_q != 3'd0) && s1_ce_q) begin
      flip_mask = 7'b000_0001 << flip_idx;
    end
    fixed_cw = s1_cw_q ^ flip_mask;
  end

  always_comb begin
    s1_cw_d    = s1_cw_q;
    s1_syn_d   = s1_syn_q;
    s1_ce_d    = s1_ce_q;
    s1_v_d     = s1_v_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    out_pos_d  = out_pos_q;
    out_v_d    = out_v_q;
    if (advance) begin
      s1_cw_d    = rcvd_data;
      s1_syn_d   = syn_in;
      s1_ce_d    = correct_en;
      s1_v_d     = in_valid;
      out_data_d = {fixed_cw[6], fixed_cw[5], fixed_cw[4], fixed_cw[2]};
      out_err_d  = (s1_syn_q != 3'd0);
      out_pos_d  = s1_syn_q;
      out_v_d    = s1_v_q;
    end
  end

  // Clear has priority over a coinciding handshake: that word is not counted.
  always_comb begin
    word_cnt_d = word_cnt_q;
    corr_cnt_d = corr_cnt_q;
    if (clr_cnt) begin
      word_cnt_d = '0;
      corr_cnt_d = '0;
    end else if (out_hs) begin
      if (word_cnt_q != CNT_MAX) word_cnt_d = word_cnt_q + CNT_ONE;
      if (out_err_q && (corr_cnt_q != CNT_MAX)) corr_cnt_d = corr_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_cw_q    <= 7'd0;
      s1_syn_q   <= 3'd0;
      s1_ce_q    <= 1'b0;
      s1_v_q     <= 1'b0;
      out_data_q <= 4'd0;
      out_err_q  <= 1'b0;
      out_pos_q  <= 3'd0;
      out_v_q    <= 1'b0;
      word_cnt_q <= '0;
      corr_cnt_q <= '0;
    end else begin
      s1_cw_q    <= s1_cw_d;
      s1_syn_q   <= s1_syn_d;
      s1_ce_q    <= s1_ce_d;
      s1_v_q     <= s1_v_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
      out_pos_q  <= out_pos_d;
      out_v_q    <= out_v_d;
      word_cnt_q <= word_cnt_d;
      corr_cnt_q <= corr_cnt_d;
    end
  end

  assign dec_data  = out_data_q;
  assign err_flag  = out_err_q;
  assign err_pos   = out_pos_q;
  assign out_valid = out_v_q;
  assign word_cnt  = word_cnt_q;
  assign corr_cnt  = corr_cnt_q;

endmodule

// File: tb/tb_hamming_rx_corrector.sv
// -----------------------------------------------------------------------------
// tb_hamming_rx_corrector
//
// Directed bench for hamming_rx_corrector. Two instances share all inputs: the
// default 16-bit counter build and a CNT_W=2 build for saturation. Inputs are
// driven 2 ns after the rising edge; the output monitor samples on the falling
// edge and pops the expected queue on every output handshake.
// Expected word layout in exp_q: {err_flag, err_pos[2:0], dec_data[3:0]}.
// -----------------------------------------------------------------------------
module tb_hamming_rx_corrector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  rcvd_data = 7'd0;
  logic        in_valid = 1'b0;
  logic        correct_en = 1'b1;
  logic        out_ready = 1'b1;
  logic        clr_cnt = 1'b0;

  logic        in_ready;
  logic [3:0]  dec_data;
  logic        err_flag;
  logic [2:0]  err_pos;
  logic        out_valid;
  logic [15:0] word_cnt;
  logic [15:0] corr_cnt;

  logic        s_in_ready;
  logic [3:0]  s_dec_data;
  logic        s_err_flag;
  logic [2:0]  s_err_pos;
  logic        s_out_valid;
  logic [1:0]  s_word_cnt;
  logic [1:0]  s_corr_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // ---------------------------------------------------------------- clock/reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  hamming_rx_corrector #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .rcvd_data(rcvd_data), .in_valid(in_valid),
    .in_ready(in_ready), .correct_en(correct_en), .dec_data(dec_data),
    .err_flag(err_flag), .err_pos(err_pos), .out_valid(out_valid),
    .out_ready(out_ready), .clr_cnt(clr_cnt), .word_cnt(word_cnt),
    .corr_cnt(corr_cnt)
  );

  hamming_rx_corrector #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .rcvd_data(rcvd_data), .in_valid(in_valid),
    .in_ready(s_in_ready), .correct_en(correct_en), .dec_data(s_dec_data),
    .err_flag(s_err_flag), .err_pos(s_err_pos), .out_valid(s_out_valid),
    .out_ready(out_ready), .clr_cnt(clr_cnt), .word_cnt(s_word_cnt),
    .corr_cnt(s_corr_cnt)
  );

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Encoder with the transmitter's bit layout.
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------------------------------------------------------- driver
  task automatic send(input logic [6:0] cw, input logic ce, input logic [7:0] exp,
                      input bit bp);
    int wait_n;
    rcvd_data  = cw;
    correct_en = ce;
    in_valid   = 1'b1;
    if (bp) out_ready = 1'($urandom_range(0, 1));
    exp_q.push_back(exp);
    #1;
    wait_n = 0;
    while (!in_ready && wait_n < 50) begin
      tick();
      if (bp) out_ready = 1'($urandom_range(0, 1));
      #1;
      wait_n++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 30) begin
      tick();
      n++;
    end
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic pulse_clr();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_word", {16'd0, word_cnt}, 32'd0);
  endtask

  // ---------------------------------------------------------------- scoreboard
  logic       prev_stall = 1'b0;
  logic [8:0] prev_out = 9'd0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_stable", {23'd0, out_valid, err_flag, err_pos, dec_data},
            {23'd0, prev_out});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_word: observed=0x%0h expected=none",
                 {err_flag, err_pos, dec_data});
        end else begin
          chk("out_word", {24'd0, err_flag, err_pos, dec_data}, {24'd0, exp_q.pop_front()});
        end
      end
      prev_stall <= out_valid && !out_ready;
      prev_out   <= {out_valid, err_flag, err_pos, dec_data};
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    int n_err;
    int flip;
    int n;
    logic [3:0] d;
    logic [6:0] cw;

    // 1. reset
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_dec_data", {28'd0, dec_data}, 32'd0);
    chk("rst_err", {28'd0, err_flag, err_pos}, 32'd0);
    chk("rst_word_cnt", {16'd0, word_cnt}, 32'd0);
    chk("rst_corr_cnt", {16'd0, corr_cnt}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // 2. clean stream 0..15, back to back, with 2-cycle latency check
    for (int i = 0; i < 16; i++) begin
      send(enc(4'(i)), 1'b1, {1'b0, 3'd0, 4'(i)}, 1'b0);
      if (i == 0) begin
        chk("lat_first_empty", {31'd0, out_valid}, 32'd0);
      end else begin
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_data", {28'd0, dec_data}, i - 1);
      end
    end
    drain();
    chk("clean_word_cnt", {16'd0, word_cnt}, 32'd16);
    chk("clean_corr_cnt", {16'd0, corr_cnt}, 32'd0);
    chk("clean_sat_word", {30'd0, s_word_cnt}, 32'd3);

    // 3. single-bit errors on 4'b1011 (codeword 7'h55)
    for (int b = 0; b < 7; b++) begin
      cw = 7'h55 ^ (7'd1 << b);
      send(cw, 1'b1, {1'b1, 3'(b + 1), 4'b1011}, 1'b0);
    end
    drain();
    chk("single_word_cnt", {16'd0, word_cnt}, 32'd23);
    chk("single_corr_cnt", {16'd0, corr_cnt}, 32'd7);

    // 4. correction off: 4'b0101 (7'h2D) with d0 flipped -> 7'h29
    send(7'h29, 1'b0, {1'b1, 3'd3, 4'b0100}, 1'b0);
    drain();
    chk("raw_word_cnt", {16'd0, word_cnt}, 32'd24);
    chk("raw_corr_cnt", {16'd0, corr_cnt}, 32'd8);

    // 5. random words under random backpressure
    pulse_clr();
    n_err = 0;
    for (int i = 0; i < 100; i++) begin
      d    = 4'($urandom_range(0, 15));
      flip = $urandom_range(0, 7);
      cw   = enc(d);
      if (flip < 7) begin
        cw = cw ^ (7'd1 << flip);
        n_err++;
        send(cw, 1'b1, {1'b1, 3'(flip + 1), d}, 1'b1);
      end else begin
        send(cw, 1'b1, {1'b0, 3'd0, d}, 1'b1);
      end
    end
    drain();
    chk("bp_word_cnt", {16'd0, word_cnt}, 32'd100);
    chk("bp_corr_cnt", {16'd0, corr_cnt}, n_err);
    chk("bp_sat_word", {30'd0, s_word_cnt}, 32'd3);
    chk("bp_sat_corr", {30'd0, s_corr_cnt}, (n_err > 3) ? 32'd3 : n_err);

    // 6. saturation at CNT_W=2 and clear during a handshake
    pulse_clr();
    chk("clr_sat_word", {30'd0, s_word_cnt}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      send(7'h55 ^ 7'h10, 1'b1, {1'b1, 3'd5, 4'b1011}, 1'b0);
    end
    drain();
    chk("sat_word", {30'd0, s_word_cnt}, 32'd3);
    chk("sat_corr", {30'd0, s_corr_cnt}, 32'd3);
    chk("wide_word", {16'd0, word_cnt}, 32'd5);
    chk("wide_corr", {16'd0, corr_cnt}, 32'd5);

    out_ready = 1'b0;
    send(7'h55 ^ 7'h01, 1'b1, {1'b1, 3'd1, 4'b1011}, 1'b0);
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    chk("clr_hs_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    clr_cnt   = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_hs_word", {16'd0, word_cnt}, 32'd0);
    chk("clr_hs_corr", {16'd0, corr_cnt}, 32'd0);
    chk("clr_hs_sat_word", {30'd0, s_word_cnt}, 32'd0);
    chk("clr_hs_sat_corr", {30'd0, s_corr_cnt}, 32'd0);
    chk("clr_hs_delivered", {31'd0, out_valid}, 32'd0);
    chk("clr_hs_queue", exp_q.size(), 32'd0);

    // ---------------------------------------------------------------- report
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
